// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage.
package wb_pkg;
  typedef enum logic [2:0] {LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4} load_e;
  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_e;
  localparam logic [4:0] RA_ADDR   = 5'd31;
  localparam logic [4:0] ZERO_ADDR = 5'd0;
endpackage

// File: rtl/load_align.sv
// load_align: big-endian byte/halfword extraction with sign/zero extension and misalignment flag.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        is_byte, is_half, sext;
  always_comb begin
    b = offset_i == 2'd0 ? raw_i[31:24] : offset_i == 2'd1 ? raw_i[23:16] :
        offset_i == 2'd2 ? raw_i[15:8] : raw_i[7:0];
    h = offset_i[1] ? raw_i[15:0] : raw_i[31:16];
    is_byte = load_type_i == LB || load_type_i == LBU;
    is_half = load_type_i == LH || load_type_i == LHU;
    sext = load_type_i == LB || load_type_i == LH;
    data_o = is_byte ? {{24{sext & b[7]}}, b} : is_half ? {{16{sext & h[15]}}, h} : raw_i;
    // codes 5-7 fall through to the word path
    misaligned_o = is_byte ? 1'b0 : is_half ? offset_i[0] : offset_i != 2'd0;
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB stage; sole register-file writer, holds loads for memory data, counts retires.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic              regWriteIn,
  input  logic              regDest,
  input  logic              linkSel,
  input  logic              memToReg,
  input  logic [2:0]        loadType,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] pcPlus8,
  input  logic              memRspValid,
  input  logic [DATA_W-1:0] memRspData,
  output logic              regWrite,
  output logic [4:0]        writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [CNT_W-1:0]  retireCount,
  output logic              alignErr,
  output logic              spuriousRsp
);
  state_e            state_q, state_d;
  logic              reg_write_q, align_err_q, spurious_q, pend_wr_q;
  logic [4:0]        write_reg_q, pend_dest_q, dest;
  logic [DATA_W-1:0] write_data_q, la_data;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        pend_type_q, la_type;
  logic [1:0]        pend_off_q, la_off;
  logic              accept, la_mis, rsp_done;
  always_comb begin
    accept = inValid && state_q == IDLE;
    rsp_done = state_q == WAIT_MEM && memRspValid;
    dest = linkSel ? RA_ADDR : (regDest ? rd : rt);
    state_d = state_q == IDLE ? ((accept && memToReg) ? WAIT_MEM : IDLE) : (memRspValid ? IDLE : WAIT_MEM);
    // one aligner: flags misalignment at accept, formats data while waiting
    la_type = state_q == IDLE ? loadType : pend_type_q;
    la_off = state_q == IDLE ? aluResult[1:0] : pend_off_q;
  end
  load_align u_align (
    .raw_i       (memRspData),
    .offset_i    (la_off),
    .load_type_i (la_type),
    .data_o      (la_data),
    .misaligned_o(la_mis)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      reg_write_q  <= 1'b0;
      write_reg_q  <= ZERO_ADDR;
      write_data_q <= '0;
      cnt_q        <= '0;
      align_err_q  <= 1'b0;
      spurious_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_dest_q  <= ZERO_ADDR;
      pend_type_q  <= 3'd0;
      pend_off_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= 1'b0;
      if (accept && !memToReg) begin
        reg_write_q  <= regWriteIn && dest != ZERO_ADDR;
        write_reg_q  <= dest;
        write_data_q <= linkSel ? pcPlus8 : aluResult;
        cnt_q        <= cnt_q + CNT_W'(1);
      end
      if (accept && memToReg) begin
        pend_wr_q   <= regWriteIn && dest != ZERO_ADDR && !la_mis;
        pend_dest_q <= dest;
        pend_type_q <= loadType;
        pend_off_q  <= aluResult[1:0];
        align_err_q <= align_err_q | la_mis;
      end
      if (rsp_done) begin
        reg_write_q  <= pend_wr_q;
        write_reg_q  <= pend_dest_q;
        write_data_q <= la_data;
        cnt_q        <= cnt_q + CNT_W'(1);
      end
      if (state_q == IDLE && memRspValid) spurious_q <= 1'b1;
    end
  end
  assign inReady     = state_q == IDLE;
  assign regWrite    = reg_write_q;
  assign writeReg    = write_reg_q;
  assign writeData   = write_data_q;
  assign retireCount = cnt_q;
  assign alignErr    = align_err_q;
  assign spuriousRsp = spurious_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed stimulus with a retire scoreboard checked by an independent monitor.
module tb_writeback_unit;
  logic        clk, rst, inValid, inReady, regWriteIn, regDest, linkSel, memToReg;
  logic [2:0]  loadType;
  logic [4:0]  rt, rd, writeReg;
  logic [31:0] aluResult, pcPlus8, memRspData, writeData, retireCount;
  logic        memRspValid, regWrite, alignErr, spuriousRsp;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] data;
    logic        cd;
    logic [31:0] cnt;
  } exp_t;
  exp_t        exp_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_cnt = 0, last_cnt = 0;

  writeback_unit dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .regWriteIn(regWriteIn),
    .regDest(regDest), .linkSel(linkSel), .memToReg(memToReg), .loadType(loadType),
    .rt(rt), .rd(rd), .aluResult(aluResult), .pcPlus8(pcPlus8), .memRspValid(memRspValid),
    .memRspData(memRspData), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .retireCount(retireCount), .alignErr(alignErr), .spuriousRsp(spuriousRsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) last_cnt = 0;
    else if (retireCount !== last_cnt) begin
      last_cnt = retireCount;
      if (exp_q.size() == 0) chk("unexpected_retire", retireCount, exp_cnt);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_regWrite", {31'd0, regWrite}, {31'd0, e.we});
        chk("wb_writeReg", {27'd0, writeReg}, {27'd0, e.wa});
        if (e.cd) chk("wb_writeData", writeData, e.data);
        chk("wb_retireCount", retireCount, e.cnt);
      end
    end else if (regWrite) chk("pulse_without_retire", {31'd0, regWrite}, 32'd0);
  end

  task automatic nonload(input logic wr, input logic rdst, input logic link, input logic [4:0] rt_a,
                         input logic [4:0] rd_a, input logic [31:0] alu, input logic [31:0] pc8,
                         input logic we, input logic [4:0] wa, input logic [31:0] data);
    inValid = 1; regWriteIn = wr; regDest = rdst; linkSel = link; memToReg = 0;
    rt = rt_a; rd = rd_a; aluResult = alu; pcPlus8 = pc8;
    exp_cnt++;
    exp_q.push_back('{we, wa, data, 1'b1, exp_cnt});
    @(posedge clk); #1;
    inValid = 0;
  endtask

  task automatic do_load(input logic [2:0] lt, input logic [4:0] rt_a, input logic [31:0] addr,
                         input logic [31:0] raw, input int dly, input logic we, input logic cd,
                         input logic [31:0] data);
    inValid = 1; regWriteIn = 1; regDest = 0; linkSel = 0; memToReg = 1; loadType = lt;
    rt = rt_a; rd = 5'd0; aluResult = addr;
    @(posedge clk); #1;
    inValid = 0;
    for (int i = 0; i < dly; i++) begin
      chk("wait_inReady", {31'd0, inReady}, 32'd0);
      @(posedge clk); #1;
    end
    exp_cnt++;
    exp_q.push_back('{we, rt_a, data, cd, exp_cnt});
    memRspValid = 1; memRspData = raw;
    @(posedge clk); #1;
    memRspValid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; inValid = 0; regWriteIn = 0; regDest = 0; linkSel = 0; memToReg = 0;
    loadType = 0; rt = 0; rd = 0; aluResult = 0; pcPlus8 = 0; memRspValid = 0; memRspData = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_writeReg", {27'd0, writeReg}, 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_retireCount", retireCount, 32'd0);
    chk("rst_alignErr", {31'd0, alignErr}, 32'd0);
    chk("rst_spurious", {31'd0, spuriousRsp}, 32'd0);
    chk("rst_inReady", {31'd0, inReady}, 32'd1);
    nonload(1, 1, 0, 5'd2, 5'd5, 32'h0000_002A, 32'h0, 1, 5'd5, 32'h0000_002A);
    chk("add_inReady", {31'd0, inReady}, 32'd1);
    do_load(3'd0, 5'd7, 32'h0000_1001, 32'h1280_3456, 3, 1, 1, 32'hFFFF_FF80);
    do_load(3'd3, 5'd8, 32'h0000_2002, 32'hAAAA_8001, 1, 1, 1, 32'h0000_8001);
    chk("align_clear", {31'd0, alignErr}, 32'd0);
    do_load(3'd2, 5'd9, 32'h0000_2001, 32'hAAAA_8001, 2, 0, 0, 32'h0);
    chk("align_set", {31'd0, alignErr}, 32'd1);
    do_load(3'd1, 5'd10, 32'h0000_0003, 32'h1280_3456, 0, 1, 1, 32'h0000_0056);
    do_load(3'd6, 5'd11, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1, 1, 32'hDEAD_BEEF);
    do_load(3'd2, 5'd12, 32'h0000_0000, 32'h8001_1234, 0, 1, 1, 32'hFFFF_8001);
    nonload(1, 0, 1, 5'd0, 5'd0, 32'h0000_1234, 32'h0040_0008, 1, 5'd31, 32'h0040_0008);
    nonload(1, 1, 0, 5'd4, 5'd0, 32'h0000_0055, 32'h0, 0, 5'd0, 32'h0000_0055);
    nonload(0, 1, 0, 5'd4, 5'd3, 32'h0000_0077, 32'h0, 0, 5'd3, 32'h0000_0077);
    nonload(1, 1, 0, 5'd0, 5'd13, 32'h0000_0101, 32'h0, 1, 5'd13, 32'h0000_0101);
    nonload(1, 0, 0, 5'd14, 5'd0, 32'h0000_0202, 32'h0, 1, 5'd14, 32'h0000_0202);
    @(posedge clk); #1;
    chk("spur_before", {31'd0, spuriousRsp}, 32'd0);
    memRspValid = 1; memRspData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    memRspValid = 0;
    chk("spur_set", {31'd0, spuriousRsp}, 32'd1);
    chk("spur_no_write", {31'd0, regWrite}, 32'd0);
    chk("spur_count", retireCount, exp_cnt);
    inValid = 1; regWriteIn = 1; memToReg = 1; loadType = 3'd4; rt = 5'd15; aluResult = 32'h40;
    @(posedge clk); #1;
    inValid = 0;
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_cnt = 0;
    chk("rstw_count", retireCount, 32'd0);
    chk("rstw_spurious", {31'd0, spuriousRsp}, 32'd0);
    chk("rstw_inReady", {31'd0, inReady}, 32'd1);
    memRspValid = 1; memRspData = 32'h1111_2222;
    @(posedge clk); #1;
    memRspValid = 0;
    chk("rstw_spur_set", {31'd0, spuriousRsp}, 32'd1);
    chk("rstw_no_write", {31'd0, regWrite}, 32'd0);
    chk("rstw_count_after", retireCount, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
